// File: rtl/masked_sbox_layer_seq.sv
// Byte-serial feeder for the 3-share masked inverse S-box pair: issues one byte of
// each share per cycle, LSB first, then reassembles the pipelined outputs.
//
// state | meaning
// IDLE  | waiting for start_i; sb_in*_o held at zero
// FEED  | one byte per share presented each cycle, rnd_req_o high
// DRAIN | issue finished, waiting for the last S-box output to be captured
// DONE  | one-cycle done_o pulse, result complete
module masked_sbox_layer_seq #(
   parameter int SBOX_LAT = 2,
   parameter int NBYTES   = 8
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [8*NBYTES-1:0]   st1_i,
   input  logic [8*NBYTES-1:0]   st2_i,
   input  logic [8*NBYTES-1:0]   st3_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [8*NBYTES-1:0]   res1_o,
   output logic [8*NBYTES-1:0]   res2_o,
   output logic [8*NBYTES-1:0]   res3_o,
   output logic                  rnd_req_o,
   output logic [7:0]            sb_in1_o,
   output logic [7:0]            sb_in2_o,
   output logic [7:0]            sb_in3_o,
   input  logic [7:0]            sb_out1_i,
   input  logic [7:0]            sb_out2_i,
   input  logic [7:0]            sb_out3_i
);

   localparam int SW = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FEED  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [IW-1:0]       iss_cnt_q, iss_cnt_d;
   logic [SW-1:0]       sh1_q, sh1_d;
   logic [SW-1:0]       sh2_q, sh2_d;
   logic [SW-1:0]       sh3_q, sh3_d;
   logic [7:0]          sb_in1_q, sb_in1_d;
   logic [7:0]          sb_in2_q, sb_in2_d;
   logic [7:0]          sb_in3_q, sb_in3_d;
   logic [SBOX_LAT-1:0] vld_q;
   logic [IW-1:0]       cap_idx_q;
   logic [SW-1:0]       res1_q, res2_q, res3_q;
   logic                feed;
   logic                cap_en;
   logic                last_issue;
   logic                last_cap;

   assign feed       = (state_q == S_FEED);
   assign cap_en     = vld_q[SBOX_LAT-1];
   assign last_issue = (iss_cnt_q == LAST_IDX);
   assign last_cap   = cap_en && (cap_idx_q == LAST_IDX);

   // State, issue and capture registers
   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= S_IDLE;
         iss_cnt_q <= '0;
         sh1_q     <= '0;
         sh2_q     <= '0;
         sh3_q     <= '0;
         sb_in1_q  <= '0;
         sb_in2_q  <= '0;
         sb_in3_q  <= '0;
         vld_q     <= '0;
         cap_idx_q <= '0;
         res1_q    <= '0;
         res2_q    <= '0;
         res3_q    <= '0;
      end else begin
         state_q   <= state_d;
         iss_cnt_q <= iss_cnt_d;
         sh1_q     <= sh1_d;
         sh2_q     <= sh2_d;
         sh3_q     <= sh3_d;
         sb_in1_q  <= sb_in1_d;
         sb_in2_q  <= sb_in2_d;
         sb_in3_q  <= sb_in3_d;
         // Valid line tracks the S-box pipeline purely by cycle count
         vld_q[0]  <= feed;
         for (int i = 1; i < SBOX_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
         end
         if (cap_en) begin
            res1_q[{cap_idx_q, 3'b000} +: 8] <= sb_out1_i;
            res2_q[{cap_idx_q, 3'b000} +: 8] <= sb_out2_i;
            res3_q[{cap_idx_q, 3'b000} +: 8] <= sb_out3_i;
            cap_idx_q <= cap_idx_q + IW'(1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      iss_cnt_d = iss_cnt_q;
      sh1_d     = sh1_q;
      sh2_d     = sh2_q;
      sh3_d     = sh3_q;
      sb_in1_d  = sb_in1_q;
      sb_in2_d  = sb_in2_q;
      sb_in3_d  = sb_in3_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d   = S_FEED;
               iss_cnt_d = '0;
               sh1_d     = st1_i;
               sh2_d     = st2_i;
               sh3_d     = st3_i;
               sb_in1_d  = st1_i[7:0];
               sb_in2_d  = st2_i[7:0];
               sb_in3_d  = st3_i[7:0];
            end
         end
         S_FEED: begin
            if (last_issue) begin
               state_d  = S_DRAIN;
               sb_in1_d = '0;
               sb_in2_d = '0;
               sb_in3_d = '0;
            end else begin
               iss_cnt_d = iss_cnt_q + IW'(1);
               sb_in1_d  = sh1_q[15:8];
               sb_in2_d  = sh2_q[15:8];
               sb_in3_d  = sh3_q[15:8];
               sh1_d     = sh1_q >> 8;
               sh2_d     = sh2_q >> 8;
               sh3_d     = sh3_q >> 8;
            end
         end
         S_DRAIN: begin
            if (last_cap) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy_o    = (state_q != S_IDLE);
      done_o    = (state_q == S_DONE);
      rnd_req_o = feed;
   end

   assign sb_in1_o = sb_in1_q;
   assign sb_in2_o = sb_in2_q;
   assign sb_in3_o = sb_in3_q;
   assign res1_o   = res1_q;
   assign res2_o   = res2_q;
   assign res3_o   = res3_q;

endmodule

// File: doc/masked_sbox_layer_seq.md
Name: masked_sbox_layer_seq

Overview:
- Byte-serial sequencer that drives the 3-share, 8-bit-per-cycle masked inverse S-box pair (two nibble S-boxes, 216 random bits per cycle).
- Accepts a full 64-bit 3-share PRINCE state and feeds it to the S-box pair one byte per cycle, least-significant byte first.
- Realigns the pipelined S-box outputs and reassembles the 64-bit 3-share result.
- Sits between the round-state register and the S-box pair. Shares are only routed, never combined.

Parameters:
- SBOX_LAT, 2, S-box pair input-to-output latency in clock cycles; legal range 1..4.
- NBYTES, 8, bytes per state; fixed at 8 for PRINCE.

Ports:
- clk  in  1  rising-edge clock
- rst_i  in  1  asynchronous reset, active-low
- start_i  in  1  one-cycle request; samples state shares
- st1_i  in  64  state share 1
- st2_i  in  64  state share 2
- st3_i  in  64  state share 3
- busy_o  out  1  high from start acceptance until done
- done_o  out  1  one-cycle pulse when the result is complete
- res1_o  out  64  result share 1
- res2_o  out  64  result share 2
- res3_o  out  64  result share 3
- rnd_req_o  out  1  high while a valid byte is presented; the PRNG advances r on each such cycle
- sb_in1_o  out  8  S-box pair share-1 input
- sb_in2_o  out  8  S-box pair share-2 input
- sb_in3_o  out  8  S-box pair share-3 input
- sb_out1_i  in  8  S-box pair share-1 output
- sb_out2_i  in  8  S-box pair share-2 output
- sb_out3_i  in  8  S-box pair share-3 output

Behaviour:
- Reset (rst_i low, asynchronous): FSM goes to IDLE; all counters cleared; busy_o, done_o, rnd_req_o, sb_in*_o and res*_o all 0. Reset mid-operation aborts; no done_o is produced for the aborted request.
- Storage:
  - One 64-bit shift register per input share.
  - One 64-bit collect register per result share.
  - sb_in*_o are driven directly from flops, so no combinational path mixes shares.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start_i high at edge E0: load the three state shift registers and load sb_in*_o with byte 0 (bits 7:0).
  - Set rnd_req_o=1 and busy_o=1; go to FEED with issue count 0.
- FEED:
  - After edge Ek (k=0..7), sb_in*_o carry byte k (bits 8k+7:8k) of each share and rnd_req_o=1.
  - After E8, sb_in*_o are zeroed, rnd_req_o=0, and the FSM goes to DRAIN.
- Capture path (runs independently of issue):
  - At edge E(k+SBOX_LAT+1), sb_out*_i are written into byte k of res*_o (bits 8k+7:8k).
  - Implemented with a SBOX_LAT-deep valid shift line plus a 3-bit capture index.
- DRAIN: waits until capture index 7 has been written at E(8+SBOX_LAT), then goes to DONE.
- DONE (one cycle, after E(8+SBOX_LAT)):
  - done_o=1 and busy_o=1.
  - Next edge: busy_o=0, return to IDLE.
- Result hold: res*_o hold their value until the next request's first capture. Bytes update in place during a later operation; consumers sample only on done_o.
- Request rules:
  - start_i while busy_o=1 is ignored.
  - start_i in the DONE cycle is ignored.
  - start_i in the first IDLE cycle after DONE is accepted.
- Latency: done_o pulses 8+SBOX_LAT cycles after E0. Default SBOX_LAT=2: done_o high after E10, busy_o high after E0..E10.
- Capture depends on cycle count only. sb_out*_i are not inspected, and X values are passed through.

Test Plan:
- Reset: hold rst_i=0 with start_i=1 and random state -> all outputs 0. Deassert rst_i: no activity until a fresh start_i.
- Functional (connected to the real S-box pair, r random): st1=0x0123456789ABCDEF, st2=st3=0 -> done_o after E10; res1^res2^res3=0xB732FD89A6405EC1.
- Masked input: random st2/st3, st1=0x0123456789ABCDEF^st2^st3 -> XOR of result shares = 0xB732FD89A6405EC1. rnd_req_o high exactly 8 cycles.
- Busy rule: start_i pulsed at E3 and in the DONE cycle -> both ignored; exactly one done_o. start_i at E11 -> accepted, busy_o high again.
- Abort: rst_i=0 after E5, then restart with all-zero shares -> no done_o for the aborted request; second result XOR = 0xBBBBBBBBBBBBBBBB.
- Latency sweep: SBOX_LAT=1 and 4 with a delay-line S-box model -> done_o after E9 and E12 respectively; result bytes equal input bytes in order, shares unmixed.
